// File: rtl/ervp_uart_tx_gen2.sv
// rtl/ervp_uart_tx_gen2.sv - buffered UART transmitter with per-frame latched line config
//
// Purpose: pushes characters into a TX FIFO and serialises them as
//   start / 5..DATA_W_MAX data bits (LSB first) / optional parity / 1, 1.5 or 2 stop bits.
//   Frame format is captured when a character leaves the FIFO, so config writes
//   never disturb a frame already on the line. Bit timing counts baud_tick pulses
//   (OSR ticks per bit).
// Ports:
//   clk, rstnn          clock, asynchronous active-low reset
//   baud_tick           1-cycle enable at OSR x baud rate
//   cfg_*               frame format, break control
//   fifo_clear          1-cycle flush of queued characters
//   wdata/wvalid/wready character push interface
//   txd                 registered serial line, idle high
//   tx_busy, tx_done    frame in progress / end-of-stop pulse
//   fifo_count, fifo_empty  FIFO occupancy
// Optional feature: define UART_TX_CTS_FLOW_EN to add the cts_n flow-control input.
module ervp_uart_tx_gen2 #(
    parameter int DATA_W_MAX = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int OSR        = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  baud_tick,
    input  logic [3:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_even,
    input  logic                  cfg_parity_stick,
    input  logic [1:0]            cfg_stop_bits,
    input  logic                  cfg_break,
    input  logic                  fifo_clear,
`ifdef UART_TX_CTS_FLOW_EN
    input  logic                  cts_n,
`endif
    input  logic [DATA_W_MAX-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  fifo_empty
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int TICK_W = $clog2(2 * OSR + 1);
    localparam logic [TICK_W-1:0] LIM_BIT = TICK_W'(OSR);
    localparam logic [TICK_W-1:0] LIM_1P5 = TICK_W'(3 * OSR / 2);
    localparam logic [TICK_W-1:0] LIM_2   = TICK_W'(2 * OSR);
    localparam logic [3:0]        NB_MIN  = 4'd5;
    localparam logic [3:0]        NB_MAX  = 4'(DATA_W_MAX);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W_MAX-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop, full, empty, cts_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    // fifo_clear beats a same-cycle push
    assign push  = wvalid && !full && !fifo_clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    // ---------------------------------------------------------------- flow control
`ifdef UART_TX_CTS_FLOW_EN
    logic cts_meta_q, cts_meta_d, cts_sync_q, cts_sync_d;

    always_comb begin
        cts_meta_d = cts_n;
        cts_sync_d = cts_meta_q;
    end

    // Resets to "not clear to send" so nothing starts before the line is sampled.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_meta_d;
            cts_sync_q <= cts_sync_d;
        end
    end

    assign cts_ok = ~cts_sync_q;
`else
    assign cts_ok = 1'b1;
`endif

    // ---------------------------------------------------------------- frame capture
    logic [DATA_W_MAX-1:0] head, data_masked;
    logic [3:0]            nbits_cfg;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        if (cfg_data_bits < NB_MIN)      nbits_cfg = NB_MIN;
        else if (cfg_data_bits > NB_MAX) nbits_cfg = NB_MAX;
        else                             nbits_cfg = cfg_data_bits;
    end

    // Unused upper bits are zeroed so they neither reach the line nor the parity.
    always_comb begin
        data_masked = '0;
        for (int i = 0; i < DATA_W_MAX; i++) begin
            data_masked[i] = head[i] && (4'(i) < nbits_cfg);
        end
    end

    // ---------------------------------------------------------------- serialiser FSM
    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d, limit;
    logic [3:0]            bit_idx_q, bit_idx_d, nbits_q, nbits_d;
    logic [DATA_W_MAX-1:0] shreg_q, shreg_d;
    logic                  par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic [1:0]            stop_sel_q, stop_sel_d;
    logic                  txd_q, txd_d, busy_q, busy_d, done_q, done_d, line_d;

    always_comb begin
        if (state_q != S_STOP)          limit = LIM_BIT;
        else if (stop_sel_q == 2'b00)   limit = LIM_BIT;
        else if (stop_sel_q == 2'b01)   limit = LIM_1P5;
        else                            limit = LIM_2;
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_idx_d  = bit_idx_q;
        nbits_d    = nbits_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop_sel_d = stop_sel_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && cts_ok) begin
                    pop        = 1'b1;
                    shreg_d    = data_masked;
                    nbits_d    = nbits_cfg;
                    par_en_d   = cfg_parity_en;
                    par_bit_d  = cfg_parity_stick ? ~cfg_parity_even
                                                  : (cfg_parity_even ? ^data_masked : ~^data_masked);
                    stop_sel_d = cfg_stop_bits;
                    tick_d     = '0;
                    bit_idx_d  = '0;
                    state_d    = S_START;
                end
            end
            default: begin
                if (baud_tick) begin
                    if (tick_q + TICK_W'(1) == limit) begin
                        tick_d = '0;
                        case (state_q)
                            S_START: state_d = S_DATA;
                            S_DATA: begin
                                shreg_d = shreg_q >> 1;
                                if (bit_idx_q == nbits_q - 4'd1)
                                    state_d = par_en_q ? S_PARITY : S_STOP;
                                else
                                    bit_idx_d = bit_idx_q + 4'd1;
                            end
                            S_PARITY: state_d = S_STOP;
                            default: begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
        endcase

        // Line level follows the next state so txd and tx_busy switch on the same edge.
        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shreg_d[0];
            S_PARITY: line_d = par_bit_d;
            default:  line_d = 1'b1;
        endcase
        txd_d  = cfg_break ? 1'b0 : line_d;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= NB_MIN;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_sel_q <= 2'b00;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            nbits_q    <= nbits_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop_sel_q <= stop_sel_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wready     = ~full;
    assign txd        = txd_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign fifo_count = count_q;
    assign fifo_empty = empty;

endmodule

// File: tb/tb_ervp_uart_tx_gen2.sv
// tb/tb_ervp_uart_tx_gen2.sv - self-checking bench for ervp_uart_tx_gen2
module tb_ervp_uart_tx_gen2;
    localparam int OSR = 16;

    logic       clk = 1'b0;
    logic       rstnn, baud_tick;
    logic [3:0] cfg_data_bits;
    logic       cfg_parity_en, cfg_parity_even, cfg_parity_stick, cfg_break, fifo_clear;
    logic [1:0] cfg_stop_bits;
    logic [8:0] wdata;
    logic       wvalid, wready, txd, tx_busy, tx_done, fifo_empty;
    logic [4:0] fifo_count;
`ifdef UART_TX_CTS_FLOW_EN
    logic       cts_n = 1'b0;
`endif

    ervp_uart_tx_gen2 dut (
        .clk(clk), .rstnn(rstnn), .baud_tick(baud_tick),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_even(cfg_parity_even), .cfg_parity_stick(cfg_parity_stick),
        .cfg_stop_bits(cfg_stop_bits), .cfg_break(cfg_break), .fifo_clear(fifo_clear),
`ifdef UART_TX_CTS_FLOW_EN
        .cts_n(cts_n),
`endif
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .txd(txd),
        .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int tick_mode = 0;              // 0 off, 1 held high, 2 random
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, done_busy_err = 0;
    bit busy_prev = 1'b0;
    bit line_q[$];                  // txd per tick while a frame is in progress
    bit exp_q[$];                   // reference per-tick line levels

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tick_mode)
                0:       baud_tick = 1'b0;
                1:       baud_tick = 1'b1;
                default: baud_tick = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (baud_tick && tx_busy) line_q.push_back(txd);
        if (tx_busy && !busy_prev) start_cyc = cyc;
        if (tx_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (tx_busy) done_busy_err++;
        end
        busy_prev = tx_busy;
    end

    // Reference: a frame is a list of levels, each lasting a whole number of ticks.
    function automatic void add_frame(input logic [8:0] w, input int nb_cfg, input bit pen,
                                      input bit pev, input bit pst, input int stp);
        int nb, ones, stop_len;
        bit p;
        nb = (nb_cfg < 5) ? 5 : ((nb_cfg > 9) ? 9 : nb_cfg);
        ones = 0;
        for (int k = 0; k < OSR; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            ones += int'(w[i]);
            for (int k = 0; k < OSR; k++) exp_q.push_back(w[i]);
        end
        if (pen) begin
            if (pst) p = !pev;
            else     p = pev ? (ones % 2 == 1) : (ones % 2 == 0);
            for (int k = 0; k < OSR; k++) exp_q.push_back(p);
        end
        stop_len = (stp == 0) ? OSR : ((stp == 1) ? 3 * OSR / 2 : 2 * OSR);
        for (int k = 0; k < stop_len; k++) exp_q.push_back(1'b1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        int bad, n;
        bad = -1;
        n = (line_q.size() < exp_q.size()) ? line_q.size() : exp_q.size();
        check({tag, "_len"}, line_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) if (bad < 0 && line_q[i] !== exp_q[i]) bad = i;
        check({tag, "_first_bad_tick"}, bad, -1);
        line_q.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [8:0] w);
        @(posedge clk); #1;
        wdata = w; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fifo_empty && !tx_busy) && n < budget);
        @(negedge clk);
        check("idle_within_budget", (n < budget), 1);
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic pen, input logic pev,
                           input logic pst, input logic [1:0] stp);
        @(posedge clk); #1;
        cfg_data_bits = nb; cfg_parity_en = pen; cfg_parity_even = pev;
        cfg_parity_stick = pst; cfg_stop_bits = stp;
    endtask

    task automatic run_frame(input logic [8:0] w, input logic [3:0] nb, input logic pen,
                             input logic pev, input logic pst, input logic [1:0] stp, input string tag);
        int d0;
        set_cfg(nb, pen, pev, pst, stp);
        add_frame(w, int'(nb), pen, pev, pst, int'(stp));
        d0 = done_cnt;
        push_word(w);
        wait_idle(8000);
        check({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, low;
        logic [9:0] bits;
        logic [8:0] w, wa, wb;
        logic [3:0] rnb;
        logic       rpen, rpev, rpst;
        logic [1:0] rstp;

        rstnn = 1'b0; cfg_break = 1'b0; fifo_clear = 1'b0; wdata = '0; wvalid = 1'b0;
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_even = 1'b0;
        cfg_parity_stick = 1'b0; cfg_stop_bits = 2'b00;
        @(posedge clk); #1;
        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_wready", wready, 1);
        repeat (2) @(posedge clk);
        #3 rstnn = 1'b1;

        // 8N1 0xA5 with one tick per clock
        tick_mode = 1;
        run_frame(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, "t2");
        for (int k = 0; k < 10; k++) bits[9 - k] = line_q[k * OSR + OSR / 2];
        check("t2_line_bits", bits, 10'b0101001011);
        check("t2_ticks", line_q.size(), 160);
        check("t2_done_latency", done_cyc - start_cyc, 160);
        check_stream("t2");

        // 7E2, 9O1.5, stick parity under random ticks
        tick_mode = 2;
        run_frame(9'h035, 4'd7, 1'b1, 1'b1, 1'b0, 2'b10, "t3a");
        check("t3a_parity", line_q[8 * OSR + OSR / 2], 0);
        check("t3a_ticks", line_q.size(), 176);
        check_stream("t3a");
        run_frame(9'h1FF, 4'd9, 1'b1, 1'b0, 1'b0, 2'b01, "t3b");
        check("t3b_parity", line_q[10 * OSR + OSR / 2], 0);
        check("t3b_ticks", line_q.size(), 200);
        check_stream("t3b");
        run_frame(9'h000, 4'd8, 1'b1, 1'b0, 1'b1, 2'b00, "t3c");
        check("t3c_stick_parity", line_q[9 * OSR + OSR / 2], 1);
        check_stream("t3c");

        // FIFO fill with the line frozen (no ticks): one frame in flight, 16 queued, rest dropped
        tick_mode = 0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        d0 = done_cnt;
        for (int i = 0; i < 18; i++) begin
            w = 9'($urandom);
            if (i < 17) add_frame(w, 8, 1'b0, 1'b0, 1'b0, 0);
            push_word(w);
        end
        @(negedge clk);
        check("t4_count_full", fifo_count, 16);
        check("t4_wready_full", wready, 0);
        check("t4_busy_frozen", tx_busy, 1);
        tick_mode = 2;
        wait_idle(20000);
        check("t4_empty_after", fifo_empty, 1);
        check("t4_frames", done_cnt - d0, 17);
        check_stream("t4");

        // fifo_clear wins over a same-cycle push and leaves the frame in flight alone
        tick_mode = 0;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            w = 9'($urandom);
            if (i == 0) add_frame(w, 8, 1'b0, 1'b0, 1'b0, 0);
            push_word(w);
        end
        @(posedge clk); #1;
        fifo_clear = 1'b1; wvalid = 1'b1; wdata = 9'h155;
        @(posedge clk); #1;
        fifo_clear = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("clr_count", fifo_count, 0);
        check("clr_empty", fifo_empty, 1);
        check("clr_busy_kept", tx_busy, 1);
        tick_mode = 1;
        wait_idle(4000);
        check("clr_frames", done_cnt - d0, 1);
        check_stream("clr");

        // Config change mid-frame applies to the next frame only
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        wa = 9'($urandom); wb = 9'($urandom);
        add_frame(wa, 8, 1'b0, 1'b0, 1'b0, 0);
        add_frame(wb, 5, 1'b0, 1'b0, 1'b0, 0);
        d0 = done_cnt;
        push_word(wa);
        push_word(wb);
        @(posedge clk); #1 cfg_data_bits = 4'd5;
        wait_idle(4000);
        check("t5_frames", done_cnt - d0, 2);
        check_stream("t5");

        // Break for 50 ticks in the middle of a frame: line low, timing untouched
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        d0 = done_cnt;
        push_word(9'h0FF);
        repeat (20) @(posedge clk);
        #1 cfg_break = 1'b1;
        @(posedge clk);
        low = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd === 1'b0) low++;
        end
        cfg_break = 1'b0;
        check("brk_low_ticks", low, 50);
        wait_idle(4000);
        check("brk_frames", done_cnt - d0, 1);
        check("brk_latency", done_cyc - start_cyc, 160);
        check("brk_txd_idle", txd, 1);
        line_q.delete();
        exp_q.delete();
        run_frame(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, "post_brk");
        check_stream("post_brk");

        // Random formats (including out-of-range data_bits) under random ticks
        tick_mode = 2;
        for (int r = 0; r < 10; r++) begin
            w = 9'($urandom); rnb = 4'($urandom); rpen = 1'($urandom);
            rpev = 1'($urandom); rpst = 1'($urandom); rstp = 2'($urandom);
            run_frame(w, rnb, rpen, rpev, rpst, rstp, "rnd");
            check_stream("rnd");
        end

`ifdef UART_TX_CTS_FLOW_EN
        tick_mode = 1;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        cts_n = 1'b1;
        repeat (3) @(posedge clk);
        wa = 9'($urandom); wb = 9'($urandom);
        add_frame(wa, 8, 1'b0, 1'b0, 1'b0, 0);
        add_frame(wb, 8, 1'b0, 1'b0, 1'b0, 0);
        push_word(wa);
        push_word(wb);
        repeat (5) @(negedge clk);
        check("cts_held_busy", tx_busy, 0);
        check("cts_held_count", fifo_count, 2);
        @(posedge clk); #1 cts_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("cts_started", tx_busy, 1);
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1 cts_n = 1'b1;
        low = 0;
        while (done_cnt == d0 && low < 400) begin
            @(negedge clk);
            low++;
        end
        check("cts_frame_completed", done_cnt - d0, 1);
        repeat (10) @(negedge clk);
        check("cts_next_held", tx_busy, 0);
        check("cts_next_count", fifo_count, 1);
        @(posedge clk); #1 cts_n = 1'b0;
        wait_idle(4000);
        check_stream("cts");
`endif

        // Asynchronous reset mid-DATA drops the frame and the queue at once
        tick_mode = 1;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        push_word(9'h000);
        push_word(9'h001);
        push_word(9'h002);
        repeat (30) @(posedge clk);
        #3 rstnn = 1'b0;
        #1;
        check("t1_txd", txd, 1);
        check("t1_busy", tx_busy, 0);
        check("t1_count", fifo_count, 0);
        check("t1_empty", fifo_empty, 1);
        check("t1_wready", wready, 1);
        @(posedge clk);
        #3 rstnn = 1'b1;
        repeat (5) @(negedge clk);
        check("t1_stays_idle", tx_busy, 0);
        line_q.delete();
        exp_q.delete();

        check("done_never_with_busy", done_busy_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
